// File: rtl/muldiv_if.sv
// Request/response bundle between the control unit and the iterative mul/div unit.
// Latency: none; this is wiring only.
// Backpressure: busy from the unit; start is ignored while busy is high.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            write_enable;

    // Requester side (control unit / register file)
    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out, write_enable
    );

    // Execution unit side
    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out, write_enable
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: done XLEN+1 edges after the accept edge; bypass cases (div by zero, overflow) after 1 edge.
// Backpressure: busy high from the cycle after accept through the done cycle; start ignored unless idle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    // mul: {hi,lo} is the running product with the multiplier shifting out of lo
    // div: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;         // product / quotient needs negating
    logic            rneg_q, rneg_d;       // remainder needs negating (dividend was negative)
    logic            byp_q, byp_d;         // result already sits in lo, skip iterations

    // Operand conditioning for the accept cycle
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    // Datapath terms for one iteration and the final sign fixup
    logic [XLEN:0]     mul_sum, div_sh, div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fixed;

    // Magnitudes, sign flags and the two special divide cases
    always_comb begin
        is_div = bus.funct3[2];
        a_sgn  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_sgn  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        a_neg  = a_sgn && bus.rs1_data[XLEN-1];
        b_neg  = b_sgn && bus.rs2_data[XLEN-1];
        a_mag  = a_neg ? ('0 - bus.rs1_data) : bus.rs1_data;
        b_mag  = b_neg ? ('0 - bus.rs2_data) : bus.rs2_data;
        b_zero = (bus.rs2_data == '0);
        ovf    = !bus.funct3[0] && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.rs2_data == '1);
    end

    // One multiply step, one restoring-divide step, and the sign-corrected final value
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_sub  = div_sh - {1'b0, opnd_q};
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? ('0 - prod) : prod;
        quo_fix  = neg_q ? ('0 - lo_q) : lo_q;
        rem_fix  = rneg_q ? ('0 - hi_q) : hi_q;
        if (f3_q[2]) begin
            fixed = f3_q[1] ? rem_fix : quo_fix;
        end else begin
            fixed = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        byp_d    = byp_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    f3_d    = bus.funct3;
                    rd_d    = bus.rd_in;
                    hi_d    = '0;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    byp_d   = 1'b0;
                    lo_d    = is_div ? a_mag : b_mag;
                    opnd_d  = is_div ? b_mag : a_mag;
                    // Special divides park their answer in lo; RUN forwards it after one cycle
                    if (is_div && b_zero) begin
                        byp_d = 1'b1;
                        lo_d  = bus.funct3[1] ? bus.rs1_data : '1;
                    end else if (is_div && ovf) begin
                        byp_d = 1'b1;
                        lo_d  = bus.funct3[1] ? '0 : bus.rs1_data;
                    end
                end
            end
            RUN: begin
                if (byp_q) begin
                    result_d = lo_q;
                    state_d  = DONE;
                end else if (cnt_q == CW'(XLEN)) begin
                    result_d = fixed;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (f3_q[2]) begin
                        hi_d = div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            byp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            byp_q    <= byp_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_q;
    assign bus.write_enable = (state_q == DONE) && (rd_q != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand sequences for start-while-busy
// and reset mid-run, then random operations checked against an arithmetic reference.
module tb_muldiv_unit;
    localparam int XLEN    = 32;
    localparam int LAT_RUN = XLEN + 1;   // edges from accept edge to first edge showing done
    localparam int LAT_BYP = 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference from the instruction definitions using wide integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_bypass(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op (caller sits #1 after a posedge), wait for done, check handshake timing.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output logic we, output int lat);
        bus.start    = 1'b1;
        bus.funct3   = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_in    = 5'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
        check("busy_in_done_cycle", 32'(bus.busy), 32'd1);
        res = bus.result;
        rdo = bus.rd_out;
        we  = bus.write_enable;
        @(posedge clk);
        #1;
        check("done_single_cycle", 32'(bus.done), 32'd0);
        check("idle_after_done", 32'(bus.busy), 32'd0);
        check("result_held", bus.result, res);
    endtask

    vec_t        tbl[14];
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        we;
    int          lat;
    bit          seen;

    initial begin
        tbl[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_RUN};
        tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, LAT_RUN};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, LAT_RUN};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, LAT_RUN};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, LAT_RUN};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, LAT_RUN};
        tbl[6]  = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        LAT_RUN};
        tbl[7]  = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         LAT_RUN};
        tbl[8]  = '{3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, LAT_BYP};
        tbl[9]  = '{3'd6, 32'd5,         32'd0,         5'd14, 32'd5,         LAT_BYP};
        tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, LAT_BYP};
        tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         LAT_BYP};
        tbl[12] = '{3'd0, 32'd3,         32'd4,         5'd0,  32'd12,        LAT_RUN};
        tbl[13] = '{3'd1, 32'd7,         32'hFFFF_FFFD, 5'd31, 32'hFFFF_FFFF, LAT_RUN};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.funct3   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_we", 32'(bus.write_enable), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, issued back to back
        foreach (tbl[i]) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, res, rdo, we, lat);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d_rd_out", i), 32'(rdo), 32'(tbl[i].rd));
            check($sformatf("vec%0d_we", i), 32'(we), 32'(tbl[i].rd != 0));
        end

        // New start with different operands at cycle 10 of a busy op is ignored
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd6; bus.rs2_data = 32'd7;
        bus.rd_in = 5'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3;
        bus.rd_in = 5'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 10;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_start_done", 32'(bus.done), 32'd1);
        check("busy_start_latency", 32'(lat), 32'(LAT_RUN));
        check("busy_start_result", bus.result, 32'd42);
        check("busy_start_rd_out", 32'(bus.rd_out), 32'd9);
        check("busy_start_we", 32'(bus.write_enable), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5;
        bus.rd_in = 5'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", bus.result, 32'd0);
        check("midreset_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("midreset_no_done", 32'(seen), 32'd0);
        run_op(3'd7, 32'd1000, 32'd3, 5'd4, res, rdo, we, lat);
        check("post_reset_result", res, 32'd1);
        check("post_reset_latency", 32'(lat), 32'(LAT_RUN));

        // Random operations against the arithmetic reference
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            run_op(f3, a, b, rd, res, rdo, we, lat);
            check($sformatf("rnd%0d_f3_%0d_a_%08h_b_%08h_result", n, f3, a, b),
                  res, ref_result(f3, a, b));
            check($sformatf("rnd%0d_latency", n), 32'(lat),
                  32'(is_bypass(f3, a, b) ? LAT_BYP : LAT_RUN));
            check($sformatf("rnd%0d_rd_out", n), 32'(rdo), 32'(rd));
            check($sformatf("rnd%0d_we", n), 32'(we), 32'(rd != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
